// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access stage of the 5-stage RV32I pipeline. It latches the EX-stage
//   result and control into the M register and drives the data-memory bus
//   using a req/ready handshake for requests and rvalid for load data. It
//   aligns and extends load data, then registers the write-back outputs.
//   It also feeds M-stage forwarding and load-use information back to decode.
//   While an access is outstanding, it stalls the upstream stages.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   ex_*                          instruction/control/data arriving from EX
//   mem_stall                     freeze PC/IF/ID/EX this cycle
//   regEN_MEM, destReg_MEM,
//   Forwarded_Data_MEM1           M-stage forwarding information
//   Memory_Read_EN                M stage holds a valid load (load-use detect)
//   dmem_req/we/addr/wdata/be     data-memory request side (zero when idle)
//   dmem_ready/rvalid/rdata       data-memory acceptance and load response
//   regEN_WB, destReg_WB,
//   writeBackData, misalign_err   registered write-back stage outputs
module mem_access_stage #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic [DataWidth-1:0]    ex_alu_result,
  input  logic [DataWidth-1:0]    ex_store_data,
  input  logic [2:0]              ex_function3,
  input  logic                    ex_memRead,
  input  logic                    ex_memWrite,
  input  logic                    ex_memtoReg,
  input  logic                    ex_regWriteEn,
  input  logic [RegAddrWidth-1:0] ex_destReg,
  output logic                    mem_stall,
  output logic                    regEN_MEM,
  output logic [RegAddrWidth-1:0] destReg_MEM,
  output logic [DataWidth-1:0]    Forwarded_Data_MEM1,
  output logic                    Memory_Read_EN,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [DataWidth-1:0]    dmem_addr,
  output logic [DataWidth-1:0]    dmem_wdata,
  output logic [3:0]              dmem_be,
  input  logic                    dmem_ready,
  input  logic                    dmem_rvalid,
  input  logic [DataWidth-1:0]    dmem_rdata,
  output logic                    regEN_WB,
  output logic [RegAddrWidth-1:0] destReg_WB,
  output logic [DataWidth-1:0]    writeBackData,
  output logic                    misalign_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // M pipeline register
  logic                    m_valid_reg;
  logic [DataWidth-1:0]    m_alu_result_reg;
  logic [DataWidth-1:0]    m_store_data_reg;
  logic [2:0]              m_function3_reg;
  logic                    m_mem_read_reg;
  logic                    m_mem_write_reg;
  logic                    m_memto_reg_reg;
  logic                    m_reg_write_en_reg;
  logic [RegAddrWidth-1:0] m_dest_reg_reg;

  logic                    memop;
  logic                    bad;
  logic                    complete;
  logic [DataWidth-1:0]    load_lane;
  logic [DataWidth-1:0]    load_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid_reg        <= 1'b0;
      m_alu_result_reg   <= '0;
      m_store_data_reg   <= '0;
      m_function3_reg    <= 3'b000;
      m_mem_read_reg     <= 1'b0;
      m_mem_write_reg    <= 1'b0;
      m_memto_reg_reg    <= 1'b0;
      m_reg_write_en_reg <= 1'b0;
      m_dest_reg_reg     <= '0;
    end else if (!mem_stall) begin
      m_valid_reg        <= ex_valid;
      m_alu_result_reg   <= ex_alu_result;
      m_store_data_reg   <= ex_store_data;
      m_function3_reg    <= ex_function3;
      m_mem_read_reg     <= ex_memRead;
      m_mem_write_reg    <= ex_memWrite;
      m_memto_reg_reg    <= ex_memtoReg;
      m_reg_write_en_reg <= ex_regWriteEn;
      m_dest_reg_reg     <= ex_destReg;
    end
  end

  // Access legality: halfword needs addr[0]=0, word needs addr[1:0]=0.
  // A store is decoded as a store even if memRead is also set, because the
  // bus write-enable follows memWrite.
  always_comb begin
    logic is_half;
    logic is_word;
    logic misaligned;
    logic illegal_load;
    logic illegal_store;
    is_half       = (m_function3_reg[1:0] == 2'b01);
    is_word       = (m_function3_reg[1:0] == 2'b10);
    misaligned    = (is_half & m_alu_result_reg[0]) |
                    (is_word & (m_alu_result_reg[1:0] != 2'b00));
    illegal_load  = (m_function3_reg == 3'b011) | (m_function3_reg[2:1] == 2'b11);
    illegal_store = m_function3_reg[2] | (m_function3_reg[1:0] == 2'b11);
    memop         = m_valid_reg & (m_mem_read_reg | m_mem_write_reg);
    bad           = memop & (misaligned |
                             (m_mem_write_reg ? illegal_store : illegal_load));
  end

  // FSM next state, bus request and completion
  always_comb begin
    state_next = state_reg;
    dmem_req   = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        dmem_req = memop & !bad;
        if (dmem_req && dmem_ready) begin
          if (m_mem_write_reg) begin
            complete = 1'b1;
          end else begin
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign mem_stall = memop & !bad & !complete;

  // Bus outputs are forced to zero whenever no request is presented
  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = 4'b0000;
    if (dmem_req) begin
      dmem_we   = m_mem_write_reg;
      dmem_addr = {m_alu_result_reg[DataWidth-1:2], 2'b00};
      if (m_mem_write_reg) begin
        case (m_function3_reg[1:0])
          2'b00: begin
            dmem_be    = 4'b0001 << m_alu_result_reg[1:0];
            dmem_wdata = {4{m_store_data_reg[7:0]}};
          end
          2'b01: begin
            dmem_be    = 4'b0011 << {m_alu_result_reg[1], 1'b0};
            dmem_wdata = {2{m_store_data_reg[15:0]}};
          end
          default: begin
            dmem_be    = 4'hF;
            dmem_wdata = m_store_data_reg;
          end
        endcase
      end else begin
        dmem_be = 4'hF;
      end
    end
  end

  // Load alignment: bring the addressed lane down to bit 0, then extend
  assign load_lane = dmem_rdata >> {m_alu_result_reg[1:0], 3'b000};

  always_comb begin
    case (m_function3_reg)
      3'b000:  load_value = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_value = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_value = {24'h000000, load_lane[7:0]};
      3'b101:  load_value = {16'h0000, load_lane[15:0]};
      default: load_value = dmem_rdata;
    endcase
  end

  // WB register: retire when M is valid and not stalled, otherwise bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      regEN_WB      <= 1'b0;
      destReg_WB    <= '0;
      writeBackData <= '0;
      misalign_err  <= 1'b0;
    end else if (m_valid_reg && !mem_stall) begin
      regEN_WB      <= m_reg_write_en_reg & !bad;
      destReg_WB    <= m_dest_reg_reg;
      writeBackData <= m_memto_reg_reg ? load_value : m_alu_result_reg;
      misalign_err  <= bad;
    end else begin
      regEN_WB      <= 1'b0;
      misalign_err  <= 1'b0;
    end
  end

  assign regEN_MEM           = m_valid_reg & m_reg_write_en_reg;
  assign destReg_MEM         = m_dest_reg_reg;
  assign Forwarded_Data_MEM1 = m_alu_result_reg;
  assign Memory_Read_EN      = m_valid_reg & m_mem_read_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Directed testbench for mem_access_stage. Every expected value below is
//   computed by hand from the intended stage behaviour.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_function3;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_memtoReg;
  logic        ex_regWriteEn;
  logic [4:0]  ex_destReg;
  logic        mem_stall;
  logic        regEN_MEM;
  logic [4:0]  destReg_MEM;
  logic [31:0] Forwarded_Data_MEM1;
  logic        Memory_Read_EN;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        regEN_WB;
  logic [4:0]  destReg_WB;
  logic [31:0] writeBackData;
  logic        misalign_err;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clock = ~clock;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_function3(ex_function3), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memtoReg(ex_memtoReg), .ex_regWriteEn(ex_regWriteEn), .ex_destReg(ex_destReg),
    .mem_stall(mem_stall), .regEN_MEM(regEN_MEM), .destReg_MEM(destReg_MEM),
    .Forwarded_Data_MEM1(Forwarded_Data_MEM1), .Memory_Read_EN(Memory_Read_EN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .regEN_WB(regEN_WB), .destReg_WB(destReg_WB), .writeBackData(writeBackData),
    .misalign_err(misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge, outputs sampled 2ns after
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ex(input logic [31:0] alu, input logic [31:0] sdata, input logic [2:0] f3,
                        input logic rd, input logic wr, input logic m2r, input logic rwe,
                        input logic [4:0] dest);
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = sdata;
    ex_function3  = f3;
    ex_memRead    = rd;
    ex_memWrite   = wr;
    ex_memtoReg   = m2r;
    ex_regWriteEn = rwe;
    ex_destReg    = dest;
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
    ex_function3  = 3'b000;
    ex_memRead    = 1'b0;
    ex_memWrite   = 1'b0;
    ex_memtoReg   = 1'b0;
    ex_regWriteEn = 1'b0;
    ex_destReg    = 5'd0;
  endtask

  // Load accepted in its first M cycle, rvalid on the following cycle
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] expected);
    set_ex(addr, 32'h0, f3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
    step();
    clear_ex();
    dmem_ready = 1'b1;
    settle();
    check({tag, " req"}, {31'h0, dmem_req}, 32'h1);
    check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    step();
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    settle();
    check({tag, " stall at rvalid"}, {31'h0, mem_stall}, 32'h0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    settle();
    check({tag, " wb_en"}, {31'h0, regEN_WB}, 32'h1);
    check({tag, " wb_data"}, writeBackData, expected);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] f3, input logic [3:0] be, input logic [31:0] wdata);
    set_ex(addr, data, f3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    dmem_ready = 1'b1;
    step();
    clear_ex();
    settle();
    check({tag, " req"}, {31'h0, dmem_req}, 32'h1);
    check({tag, " we"}, {31'h0, dmem_we}, 32'h1);
    check({tag, " be"}, {28'h0, dmem_be}, {28'h0, be});
    check({tag, " wdata"}, dmem_wdata, wdata);
    check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    check({tag, " stall"}, {31'h0, mem_stall}, 32'h0);
    step();
    dmem_ready = 1'b0;
    settle();
    check({tag, " wb_en"}, {31'h0, regEN_WB}, 32'h0);
    check({tag, " bus idle"}, {31'h0, dmem_req}, 32'h0);
  endtask

  task automatic do_bad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                        input logic is_store);
    set_ex(addr, 32'h5555_5555, f3, !is_store, is_store, !is_store, !is_store, 5'd4);
    dmem_ready = 1'b1;
    step();
    clear_ex();
    settle();
    check({tag, " no req"}, {31'h0, dmem_req}, 32'h0);
    check({tag, " no be"}, {28'h0, dmem_be}, 32'h0);
    check({tag, " no stall"}, {31'h0, mem_stall}, 32'h0);
    step();
    dmem_ready = 1'b0;
    settle();
    check({tag, " err pulse"}, {31'h0, misalign_err}, 32'h1);
    check({tag, " wb_en suppressed"}, {31'h0, regEN_WB}, 32'h0);
    step();
    settle();
    check({tag, " err cleared"}, {31'h0, misalign_err}, 32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    clear_ex();
    step();
    step();
    settle();
    check("reset regEN_WB", {31'h0, regEN_WB}, 32'h0);
    check("reset destReg_WB", {27'h0, destReg_WB}, 32'h0);
    check("reset writeBackData", writeBackData, 32'h0);
    check("reset misalign_err", {31'h0, misalign_err}, 32'h0);
    check("reset mem_stall", {31'h0, mem_stall}, 32'h0);
    check("reset dmem_req", {31'h0, dmem_req}, 32'h0);
    check("reset regEN_MEM", {31'h0, regEN_MEM}, 32'h0);
    check("reset Memory_Read_EN", {31'h0, Memory_Read_EN}, 32'h0);
    reset = 1'b0;
    #1;

    // ALU op x5 <= 0x1234
    set_ex(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    step();
    clear_ex();
    settle();
    check("alu regEN_MEM", {31'h0, regEN_MEM}, 32'h1);
    check("alu destReg_MEM", {27'h0, destReg_MEM}, 32'd5);
    check("alu fwd data", Forwarded_Data_MEM1, 32'h0000_1234);
    check("alu no req", {31'h0, dmem_req}, 32'h0);
    check("alu no stall", {31'h0, mem_stall}, 32'h0);
    step();
    settle();
    check("alu regEN_WB", {31'h0, regEN_WB}, 32'h1);
    check("alu destReg_WB", {27'h0, destReg_WB}, 32'd5);
    check("alu writeBackData", writeBackData, 32'h0000_1234);
    step();
    settle();
    check("bubble regEN_WB", {31'h0, regEN_WB}, 32'h0);
    check("bubble data holds", writeBackData, 32'h0000_1234);

    // Stores
    do_store("SB 0x103", 32'h0000_0103, 32'h1234_56AB, 3'b000, 4'b1000, 32'hABAB_ABAB);
    do_store("SB 0x100", 32'h0000_0100, 32'h0000_0011, 3'b000, 4'b0001, 32'h1111_1111);
    do_store("SH 0x102", 32'h0000_0102, 32'h1234_BEEF, 3'b001, 4'b1100, 32'hBEEF_BEEF);
    do_store("SW 0x104", 32'h0000_0104, 32'hCAFE_F00D, 3'b010, 4'b1111, 32'hCAFE_F00D);

    // Store held off by ready: stall until accepted
    set_ex(32'h0000_0200, 32'h0000_0077, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    clear_ex();
    settle();
    check("SW wait stall", {31'h0, mem_stall}, 32'h1);
    check("SW wait req", {31'h0, dmem_req}, 32'h1);
    step();
    dmem_ready = 1'b1;
    settle();
    check("SW accept stall", {31'h0, mem_stall}, 32'h0);
    step();
    dmem_ready = 1'b0;
    settle();
    check("SW done req", {31'h0, dmem_req}, 32'h0);

    // LH 0x102: ready at N (after one wait cycle), rvalid at N+3
    set_ex(32'h0000_0102, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    step();
    clear_ex();
    settle();
    check("LH load-use flag", {31'h0, Memory_Read_EN}, 32'h1);
    check("LH pre-accept stall", {31'h0, mem_stall}, 32'h1);
    check("LH pre-accept be", {28'h0, dmem_be}, 32'hF);
    step();
    dmem_ready = 1'b1;
    settle();
    check("LH N stall", {31'h0, mem_stall}, 32'h1);
    check("LH N addr", dmem_addr, 32'h0000_0100);
    check("LH N we", {31'h0, dmem_we}, 32'h0);
    step();
    dmem_ready = 1'b0;
    settle();
    check("LH N+1 stall", {31'h0, mem_stall}, 32'h1);
    check("LH N+1 no req", {31'h0, dmem_req}, 32'h0);
    step();
    settle();
    check("LH N+2 stall", {31'h0, mem_stall}, 32'h1);
    check("LH N+2 no wb", {31'h0, regEN_WB}, 32'h0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8001_0000;
    settle();
    check("LH N+3 stall", {31'h0, mem_stall}, 32'h0);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    settle();
    check("LH wb_en", {31'h0, regEN_WB}, 32'h1);
    check("LH wb_rd", {27'h0, destReg_WB}, 32'd7);
    check("LH wb_data", writeBackData, 32'hFFFF_8001);

    // Load extension cases
    do_load("LBU 0x101", 32'h0000_0101, 3'b100, 32'h0000_F000, 32'h0000_00F0);
    do_load("LB 0x101",  32'h0000_0101, 3'b000, 32'h0000_F000, 32'hFFFF_FFF0);
    do_load("LHU 0x102", 32'h0000_0102, 3'b101, 32'h8001_0000, 32'h0000_8001);
    do_load("LH 0x100",  32'h0000_0100, 3'b001, 32'h1234_7FFE, 32'h0000_7FFE);
    do_load("LB 0x103",  32'h0000_0103, 3'b000, 32'h7F00_0000, 32'h0000_007F);
    do_load("LW 0x100",  32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Bad accesses
    do_bad("LW 0x102 misaligned", 32'h0000_0102, 3'b010, 1'b0);
    do_bad("LH 0x101 misaligned", 32'h0000_0101, 3'b001, 1'b0);
    do_bad("SW 0x101 misaligned", 32'h0000_0101, 3'b010, 1'b1);
    do_bad("load f3=011 illegal", 32'h0000_0100, 3'b011, 1'b0);
    do_bad("store f3=100 illegal", 32'h0000_0100, 3'b100, 1'b1);

    // Reset during WAIT_RSP; late rvalid must be ignored
    set_ex(32'h0000_0300, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12);
    dmem_ready = 1'b1;
    step();
    clear_ex();
    step();
    dmem_ready = 1'b0;
    settle();
    check("rst-wait stall before reset", {31'h0, mem_stall}, 32'h1);
    reset = 1'b1;
    step();
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1357_9BDF;
    settle();
    check("rst-wait stall", {31'h0, mem_stall}, 32'h0);
    check("rst-wait req", {31'h0, dmem_req}, 32'h0);
    check("rst-wait regEN_MEM", {31'h0, regEN_MEM}, 32'h0);
    step();
    dmem_rvalid = 1'b0;
    settle();
    check("rst-wait regEN_WB", {31'h0, regEN_WB}, 32'h0);
    check("rst-wait wb data", writeBackData, 32'h0);

    // Pipeline still works after that reset
    do_load("post-reset LW", 32'h0000_0400, 3'b010, 32'h0246_8ACE, 32'h0246_8ACE);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  // Watchdog: the directed sequence is short, so this only fires on a hang
  initial begin
    #100000;
    num_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $fatal(1, "timeout");
  end

endmodule
